fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/sap1_pkg.sv | 41 ++++
 rtl/ring_counter.sv | 44 ++++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 style fetch sequencer: T-state encodings,
// default widths, opcode values and the ring-counter step function.
package sap1_pkg;

  // Default ROM geometry
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // One-hot T-states, bit0 = T1
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  // Opcodes carried in the upper nibble of a ROM word
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Successor T-state; any encoding that is not exactly one-hot restarts at T1
  function automatic logic [5:0] next_t_state(input logic [5:0] cur);
    logic [5:0] nxt;
    case (cur)
      T1:      nxt = T2;
      T2:      nxt = T3;
      T3:      nxt = T4;
      T4:      nxt = T5;
      T5:      nxt = T6;
      T6:      nxt = T1;
      default: nxt = T1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot ring counter; advances only when enabled, but an illegal
// encoding is forced back to T1 on the next edge regardless of the enable.
module ring_counter
  import sap1_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR_bar,
  input  logic       advance,
  output logic [5:0] t_state
);

  logic [5:0] t_state_r;
  logic [5:0] t_state_nxt_s;
  logic       legal_s;

  // Legality check and next-state selection
  always_comb begin
    t_state_nxt_s = t_state_r;
    legal_s       = 1'b0;
    case (t_state_r)
      T1, T2, T3, T4, T5, T6: legal_s = 1'b1;
      default:                legal_s = 1'b0;
    endcase
    if (!legal_s) begin
      t_state_nxt_s = T1;
    end else if (advance) begin
      t_state_nxt_s = next_t_state(t_state_r);
    end else begin
      t_state_nxt_s = t_state_r;
    end
  end

  // State register, cleared asynchronously to T1
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      t_state_r <= T1;
    end else begin
      t_state_r <= t_state_nxt_s;
    end
  end

  assign t_state = t_state_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the ROM address/enable through the T1..T6 ring,
// maintains pc, MAR and IR, and latches a halt request taken in T4.
module fetch_sequencer
  import sap1_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     CLK,
  input  logic                     CLR_bar,
  input  logic                     run,
  input  logic                     HLT,
  input  logic                     mar_from_ir,
  input  logic                     mem_rd,
  input  logic [DATA_W-1:0]        data,
  output logic [ADDR_W-1:0]        address,
  output logic                     CE_bar,
  output logic [5:0]               t_state,
  output logic [ADDR_W-1:0]        pc,
  output logic [DATA_W-ADDR_W-1:0] opcode,
  output logic [ADDR_W-1:0]        operand,
  output logic                     halted
);

  logic                     advance_s;
  logic [5:0]               t_state_s;
  logic [ADDR_W-1:0]        pc_r;
  logic [ADDR_W-1:0]        mar_r;
  logic [DATA_W-ADDR_W-1:0] opcode_r;
  logic [ADDR_W-1:0]        operand_r;
  logic                     halted_r;
  logic                     ce_bar_r;

  assign advance_s = run & ~halted_r;

  ring_counter u_ring (
    .CLK     (CLK),
    .CLR_bar (CLR_bar),
    .advance (advance_s),
    .t_state (t_state_s)
  );

  // Per-T-state datapath actions. CE_bar is registered, so it is computed on
  // the edge that enters the cycle it covers: low for T3, and low for T5 when
  // mem_rd is presented at the T4->T5 edge. A held or halted edge drives it high.
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      pc_r      <= '0;
      mar_r     <= '0;
      opcode_r  <= '0;
      operand_r <= '0;
      halted_r  <= 1'b0;
      ce_bar_r  <= 1'b1;
    end else if (advance_s) begin
      case (t_state_s)
        T1: begin
          mar_r    <= pc_r;
          ce_bar_r <= 1'b1;
        end
        T2: begin
          pc_r     <= pc_r + ADDR_W'(1);
          ce_bar_r <= 1'b0;
        end
        T3: begin
          opcode_r  <= data[DATA_W-1:ADDR_W];
          operand_r <= data[ADDR_W-1:0];
          ce_bar_r  <= 1'b1;
        end
        T4: begin
          if (HLT) begin
            halted_r <= 1'b1;
            ce_bar_r <= 1'b1;
          end else begin
            if (mar_from_ir) begin
              mar_r <= operand_r;
            end else begin
              mar_r <= mar_r;
            end
            ce_bar_r <= ~mem_rd;
          end
        end
        T5, T6: begin
          ce_bar_r <= 1'b1;
        end
        default: begin
          ce_bar_r <= 1'b1;
        end
      endcase
    end else begin
      ce_bar_r <= 1'b1;
    end
  end

  assign address = mar_r;
  assign CE_bar  = ce_bar_r;
  assign t_state = t_state_s;
  assign pc      = pc_r;
  assign opcode  = opcode_r;
  assign operand = operand_r;
  assign halted  = halted_r;

endmodule
